// File: rtl/ps2_command_sequencer.sv
// PS/2 set-2 make codes -> 4-char ASCII command word with valid/ready hand-off and LCD echo.
// Optional typematic-repeat filter: define PS2CMD_TYPEMATIC_FILTER_EN.
module ps2_command_sequencer #(
    parameter logic [19:0] PREFIX_TIMEOUT = 20'd500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [7:0]  scancode,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [31:0] cmd_data,
    output logic [2:0]  char_count,
    output logic        lcd_we,
    output logic [7:0]  lcd_char,
    output logic        overflow,
    output logic        dropped
);

    typedef enum logic [2:0] {COLLECT, BREAK, EXT, EXT_BREAK, SEND} state_t;

    state_t      state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic [2:0]  count_q, count_d;
    logic [19:0] tmo_q, tmo_d;
    logic        lcd_we_q, lcd_we_d;
    logic [7:0]  lcd_char_q, lcd_char_d;
    logic        ovf_q, ovf_d;
    logic        drop_q, drop_d;
    logic [8:0]  mapped;
    logic        filtered;
`ifdef PS2CMD_TYPEMATIC_FILTER_EN
    logic [7:0]  last_q, last_d;
`endif

    // {hit, ascii} for the printable keys this sequencer understands
    function automatic logic [8:0] map_ascii(input logic [7:0] sc);
        case (sc)
            8'h1C: return {1'b1, 8'h41}; 8'h32: return {1'b1, 8'h42};
            8'h21: return {1'b1, 8'h43}; 8'h23: return {1'b1, 8'h44};
            8'h24: return {1'b1, 8'h45}; 8'h2B: return {1'b1, 8'h46};
            8'h34: return {1'b1, 8'h47}; 8'h33: return {1'b1, 8'h48};
            8'h43: return {1'b1, 8'h49}; 8'h3B: return {1'b1, 8'h4A};
            8'h42: return {1'b1, 8'h4B}; 8'h4B: return {1'b1, 8'h4C};
            8'h3A: return {1'b1, 8'h4D}; 8'h31: return {1'b1, 8'h4E};
            8'h44: return {1'b1, 8'h4F}; 8'h4D: return {1'b1, 8'h50};
            8'h15: return {1'b1, 8'h51}; 8'h2D: return {1'b1, 8'h52};
            8'h1B: return {1'b1, 8'h53}; 8'h2C: return {1'b1, 8'h54};
            8'h3C: return {1'b1, 8'h55}; 8'h2A: return {1'b1, 8'h56};
            8'h1D: return {1'b1, 8'h57}; 8'h22: return {1'b1, 8'h58};
            8'h35: return {1'b1, 8'h59}; 8'h1A: return {1'b1, 8'h5A};
            8'h45: return {1'b1, 8'h30}; 8'h16: return {1'b1, 8'h31};
            8'h1E: return {1'b1, 8'h32}; 8'h26: return {1'b1, 8'h33};
            8'h25: return {1'b1, 8'h34}; 8'h2E: return {1'b1, 8'h35};
            8'h36: return {1'b1, 8'h36}; 8'h3D: return {1'b1, 8'h37};
            8'h3E: return {1'b1, 8'h38}; 8'h46: return {1'b1, 8'h39};
            8'h29: return {1'b1, 8'h20};
            default: return 9'h000;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        count_d    = count_q;
        tmo_d      = tmo_q;
        lcd_we_d   = 1'b0;
        lcd_char_d = lcd_char_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        mapped     = map_ascii(scancode);
        filtered   = 1'b0;
`ifdef PS2CMD_TYPEMATIC_FILTER_EN
        last_d     = last_q;
        filtered   = (scancode == last_q);
`endif
        case (state_q)
            COLLECT: begin
                if (key_valid) begin
                    if (scancode == 8'hF0) begin
                        state_d = BREAK;
                        tmo_d   = 20'd0;
                    end else if (scancode == 8'hE0) begin
                        state_d = EXT;
                        tmo_d   = 20'd0;
                    end else if (!filtered) begin
                        if (scancode == 8'h5A) begin
                            if (count_q != 3'd0) state_d = SEND;
                        end else if (scancode == 8'h66) begin
                            if (count_q != 3'd0) begin
                                buf_d   = buf_q >> 8;
                                count_d = count_q - 3'd1;
                            end
                        end else if (mapped[8]) begin
                            if (count_q < 3'd4) begin
                                buf_d      = {buf_q[23:0], mapped[7:0]};
                                count_d    = count_q + 3'd1;
                                lcd_we_d   = 1'b1;
                                lcd_char_d = mapped[7:0];
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
`ifdef PS2CMD_TYPEMATIC_FILTER_EN
                        if (mapped[8] || scancode == 8'h5A || scancode == 8'h66)
                            last_d = scancode;
`endif
                    end
                end
            end
            BREAK, EXT_BREAK: begin
                if (key_valid) begin
                    state_d = COLLECT;
`ifdef PS2CMD_TYPEMATIC_FILTER_EN
                    last_d  = 8'h00;
`endif
                end else if (tmo_q == PREFIX_TIMEOUT - 20'd1) begin
                    state_d = COLLECT;
                end else begin
                    tmo_d = tmo_q + 20'd1;
                end
            end
            EXT: begin
                if (key_valid) begin
                    if (scancode == 8'hF0) begin
                        state_d = EXT_BREAK;
                        tmo_d   = 20'd0;
                    end else begin
                        state_d = COLLECT;
                    end
                end else if (tmo_q == PREFIX_TIMEOUT - 20'd1) begin
                    state_d = COLLECT;
                end else begin
                    tmo_d = tmo_q + 20'd1;
                end
            end
            SEND: begin
                // bytes arriving while the word waits are lost, even on the accept edge
                if (key_valid) drop_d = 1'b1;
                if (cmd_ready) begin
                    buf_d   = 32'd0;
                    count_d = 3'd0;
                    ovf_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= COLLECT;
            buf_q      <= 32'd0;
            count_q    <= 3'd0;
            tmo_q      <= 20'd0;
            lcd_we_q   <= 1'b0;
            lcd_char_q <= 8'd0;
            ovf_q      <= 1'b0;
            drop_q     <= 1'b0;
`ifdef PS2CMD_TYPEMATIC_FILTER_EN
            last_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            lcd_we_q   <= lcd_we_d;
            lcd_char_q <= lcd_char_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
`ifdef PS2CMD_TYPEMATIC_FILTER_EN
            last_q     <= last_d;
`endif
        end
    end

    assign cmd_valid  = (state_q == SEND);
    assign cmd_data   = buf_q;
    assign char_count = count_q;
    assign lcd_we     = lcd_we_q;
    assign lcd_char   = lcd_char_q;
    assign overflow   = ovf_q;
    assign dropped    = drop_q;

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Directed bench for ps2_command_sequencer: queue-based reference model checked every cycle plus literal checkpoints.
module tb_ps2_command_sequencer;
    localparam logic [19:0] T = 20'd20;

    logic        clk = 1'b0;
    logic        reset = 1'b1, key_valid = 1'b0, cmd_ready = 1'b0;
    logic [7:0]  scancode = 8'h00;
    logic        cmd_valid, lcd_we, overflow, dropped;
    logic [31:0] cmd_data;
    logic [2:0]  char_count;
    logic [7:0]  lcd_char;

    ps2_command_sequencer #(.PREFIX_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .scancode(scancode),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .char_count(char_count), .lcd_we(lcd_we), .lcd_char(lcd_char),
        .overflow(overflow), .dropped(dropped));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- reference model: the buffer is a queue of ASCII bytes, oldest first ----
    logic [7:0] amap [logic [7:0]];
    logic [7:0] q [$];
    logic       m_send = 0, m_ovf = 0, m_drop = 0, m_we = 0;
    logic [7:0] m_char = 0, last_make = 0;
    bit         discard = 0, ext = 0;
    int         idle = 0;
    bit         filter_on = 0;

    function automatic logic [31:0] fold();
        logic [31:0] w = 32'd0;
        foreach (q[i]) w = {w[23:0], q[i]};
        return w;
    endfunction

    task automatic model_step();
        if (reset) begin
            q.delete(); m_send = 0; m_ovf = 0; m_drop = 0; m_we = 0; m_char = 0;
            discard = 0; ext = 0; idle = 0; last_make = 0;
            return;
        end
        m_we = 0;
        if (m_send) begin
            if (key_valid) m_drop = 1;
            if (cmd_ready) begin q.delete(); m_ovf = 0; m_send = 0; end
        end else if (discard || ext) begin
            if (key_valid) begin
                if (ext && scancode == 8'hF0) begin ext = 0; discard = 1; idle = 0; end
                else begin
                    if (discard) last_make = 0;
                    discard = 0; ext = 0;
                end
            end else if (idle == int'(T) - 1) begin
                discard = 0; ext = 0;
            end else idle++;
        end else if (key_valid) begin
            if (scancode == 8'hF0) begin discard = 1; idle = 0; end
            else if (scancode == 8'hE0) begin ext = 1; idle = 0; end
            else if (!(filter_on && scancode == last_make)) begin
                if (scancode == 8'h5A) begin
                    if (q.size() > 0) m_send = 1;
                    last_make = scancode;
                end else if (scancode == 8'h66) begin
                    if (q.size() > 0) void'(q.pop_back());
                    last_make = scancode;
                end else if (amap.exists(scancode)) begin
                    if (q.size() < 4) begin
                        q.push_back(amap[scancode]); m_we = 1; m_char = amap[scancode];
                    end else m_ovf = 1;
                    last_make = scancode;
                end
            end
        end
    endtask

    bit started = 0;
    int valid_cycles = 0;
    logic [31:0] last_cmd = 0;
    logic [7:0] echo [$];

    initial forever begin @(posedge clk); model_step(); end

    always @(negedge clk) if (started) begin
        chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_send});
        if (m_send) chk("cmd_data", cmd_data, fold());
        chk("char_count", {29'd0, char_count}, q.size());
        chk("lcd_we", {31'd0, lcd_we}, {31'd0, m_we});
        chk("lcd_char", {24'd0, lcd_char}, {24'd0, m_char});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("dropped", {31'd0, dropped}, {31'd0, m_drop});
        if (cmd_valid) begin valid_cycles++; last_cmd = cmd_data; end
        if (lcd_we) echo.push_back(lcd_char);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [7:0] b);
        key_valid = 1; scancode = b;
        tick(1);
        key_valid = 0;
        tick(1);
    endtask

    task automatic keys(input logic [7:0] seq [$]);
        foreach (seq[i]) key(seq[i]);
    endtask

    initial begin
        logic [7:0] letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
            8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,
            8'h1D,8'h22,8'h35,8'h1A};
        logic [7:0] digits [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
        foreach (letters[i]) amap[letters[i]] = 8'h41 + 8'(i);
        foreach (digits[i]) amap[digits[i]] = 8'h30 + 8'(i);
        amap[8'h29] = 8'h20;
`ifdef PS2CMD_TYPEMATIC_FILTER_EN
        filter_on = 1;
`endif
        tick(3);
        started = 1;
        reset = 0;
        chk("reset cmd_valid", {31'd0, cmd_valid}, 0);
        chk("reset char_count", {29'd0, char_count}, 0);
        chk("reset lcd", {23'd0, lcd_we, lcd_char}, 0);
        chk("reset sticky", {30'd0, overflow, dropped}, 0);

        // T, A, P, enter with processor always ready
        cmd_ready = 1; echo.delete(); valid_cycles = 0;
        keys('{8'h2C,8'hF0,8'h2C,8'h1C,8'hF0,8'h1C,8'h4D,8'hF0,8'h4D,8'h5A});
        tick(2);
        chk("tap echo count", echo.size(), 3);
        if (echo.size() == 3) begin
            chk("tap echo0", {24'd0, echo[0]}, 32'h54);
            chk("tap echo1", {24'd0, echo[1]}, 32'h41);
            chk("tap echo2", {24'd0, echo[2]}, 32'h50);
        end
        chk("tap valid cycles", valid_cycles, 1);
        chk("tap cmd", last_cmd, 32'h00544150);
        chk("tap count", {29'd0, char_count}, 0);

        // five digits, enter, processor stalls for 10 cycles
        cmd_ready = 0; valid_cycles = 0;
        keys('{8'h16,8'hF0,8'h16,8'h1E,8'hF0,8'h1E,8'h26,8'hF0,8'h26,8'h25,8'hF0,8'h25,8'h2E,8'hF0,8'h2E});
        chk("ovf set", {31'd0, overflow}, 1);
        key(8'h5A);
        tick(9);
        chk("stall valid cycles", valid_cycles, 10);
        chk("stall cmd", cmd_data, 32'h31323334);
        chk("stall ovf", {31'd0, overflow}, 1);
        cmd_ready = 1;
        tick(2);
        chk("ovf cleared", {31'd0, overflow}, 0);
        chk("accepted", {31'd0, cmd_valid}, 0);

        // add then backspace, then enter on an empty buffer
        valid_cycles = 0;
        key(8'h1C);
        chk("bs count1", {29'd0, char_count}, 1);
        keys('{8'hF0,8'h1C,8'h66});
        chk("bs count0", {29'd0, char_count}, 0);
        keys('{8'hF0,8'h66,8'h5A});
        tick(3);
        chk("empty enter", valid_cycles, 0);

        // extended make / break sequences are swallowed
        cmd_ready = 0; echo.delete();
        keys('{8'hE0,8'h75,8'hE0,8'hF0,8'h75});
        chk("ext no echo", echo.size(), 0);
        chk("ext count", {29'd0, char_count}, 0);

        // prefix still active before timeout: byte is discarded
        key(8'hF0); tick(5); key(8'h1C);
        chk("prefix discard", echo.size(), 0);

        // prefix timeout then 'A'
        key(8'hF0); tick(30); key(8'h1C);
        chk("timeout echo", echo.size(), 1);
        chk("timeout char", {24'd0, lcd_char}, 32'h41);
        chk("timeout count", {29'd0, char_count}, 1);

        // drop in SEND, then reset while valid
        key(8'h5A);
        chk("send valid", {31'd0, cmd_valid}, 1);
        key(8'h1C);
        chk("dropped set", {31'd0, dropped}, 1);
        reset = 1; tick(1); reset = 0;
        chk("rst valid", {31'd0, cmd_valid}, 0);
        chk("rst count", {29'd0, char_count}, 0);
        chk("rst data", cmd_data, 0);
        chk("rst flags", {29'd0, lcd_we, overflow, dropped}, 0);
        chk("rst lcd_char", {24'd0, lcd_char}, 0);

        // typematic repeats
        keys('{8'h1C,8'h1C,8'h1C,8'hF0,8'h1C});
        chk("typematic count", {29'd0, char_count}, filter_on ? 1 : 3);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
